jedro_1_alu_decoder: RTL and testbench
======================================

# jedro_1_alu_decoder

Decode/issue stage directly upstream of the ALU stage. Accepts one 32-bit RV32I instruction per cycle over a valid/ready handshake and decodes the OP, OP-IMM and LUI classes. It reads operands from the register file and resolves read-after-write hazards against instructions still in flight in the ALU, using a stall FSM plus optional forwarding. Its registered outputs drive the ALU's select, operand, destination and write-back inputs.

## Interface
- DATA_WIDTH, 32, operand width.
- REG_ADDR_WIDTH, 5, register address width.
- ALU_OP_WIDTH, 4, ALU select width.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- instr_i  in  32  instruction word.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  decoder accepts instr_i this cycle; combinational from FSM state and hazard check.
- rf_addr_a_o / rf_addr_b_o  out  REG_ADDR_WIDTH  register file read addresses (rs1/rs2); combinational from instr_i.
- rf_data_a_i / rf_data_b_i  in  DATA_WIDTH  register file read data; combinational, no write-through.
- alu_res_i  in  DATA_WIDTH  ALU registered result (res_ro).
- alu_dest_addr_i  in  REG_ADDR_WIDTH  ALU registered destination.
- alu_wb_i  in  1  ALU registered write-back flag.
- alu_sel_o  out  ALU_OP_WIDTH  registered ALU operation.
- alu_op_a_o / alu_op_b_o  out  DATA_WIDTH  registered operands.
- alu_dest_addr_o  out  REG_ADDR_WIDTH  registered rd.
- alu_wb_o  out  1  registered write-back enable.
- illegal_instr_o  out  1  registered one-cycle pulse for an accepted unsupported instruction.

## Operation
- A transfer occurs when instr_valid_i and instr_ready_o are both 1. Each accepted instruction issues on the next edge.
- A cycle with no transfer issues a bubble: sel=ALU_OP_ADD, op_a=op_b=0, dest=0, wb=0.
- ALU select is {funct7[5], funct3}.
  - funct7[5] is only legal for ADD/SUB and SRL/SRA in OP, and for SRAI in OP-IMM.
  - ADDI with funct7[5] set remains ADD; the immediate bit is not used as an op bit.
- OP: op_a=rs1, op_b=rs2.
  - Legal funct7 values: 0000000 everywhere, plus 0100000 for funct3 000/101.
- OP-IMM: op_b = sign-extended I-immediate.
  - SLLI legal only with funct7 0000000.
  - SRLI/SRAI legal only with funct7 0000000/0100000.
- LUI: sel=ADD, op_a=0, op_b={imm[31:12],12'b0}.
- An illegal instruction is still consumed. It issues as a bubble and illegal_instr_o=1 for one cycle.
- rd=x0 forces wb=0. A source x0 always reads 0 and never causes a hazard.
- A hazard exists when a source of the presented instruction equals the rd of a wb=1 instruction still in flight (not yet written to the register file).
- The FSM has two states:
  - RUN: ready=1 unless a hazard exists. On a hazard, go to STALL and load stall_cnt with the required bubble count.
  - STALL: ready=0 and bubbles issue. stall_cnt decrements each cycle; return to RUN when it reaches 0.
- In RUN with instr_valid_i=0: issue a bubble and stay in RUN.

## Timing
- Latency: accepted at edge N, visible on alu_*_o after edge N.
- Reset values:
  - All alu_*_o outputs are 0; note ALU_OP_ADD=0.
  - illegal_instr_o=0.
  - FSM state=RUN, stall_cnt=0.
  - instr_ready_o=1 in the cycle after reset.
- Reset asserted mid-STALL aborts the stall and returns to RUN with the reset values above.
- Instructions are never dropped or duplicated. While ready=0, instr_i must be held by upstream.
- Register file write happens on the edge after the ALU result is registered (from res_ro/wb_ro).

## Configuration
- JEDRO_1_FORWARDING_EN defined:
  - A dependency on the instruction currently in alu_*_o costs 1 stall cycle.
  - In the following cycle the operand is taken from alu_res_i when alu_wb_i=1 and alu_dest_addr_i matches.
  - Forwarding takes priority over rf_data.
- JEDRO_1_FORWARDING_EN undefined:
  - There is no forwarding path.
  - A dependency on the alu_*_o instruction costs 2 stall cycles.
  - A dependency on the alu_res_i instruction costs 1 stall cycle.
  - Operands always come from rf_data.

## Structure
- Shared package jedro_1_defines:
  - ALU_OP_* constants: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
  - Opcode constants: OP=0110011, OP-IMM=0010011, LUI=0110111.
  - The FSM state enum.
  - DATA_WIDTH, REG_ADDR_WIDTH, ALU_OP_WIDTH.
- One sub-module, jedro_1_instr_fields: purely combinational field extraction, immediate generation and legality check.

## Test plan
- Reset, then `add x3,x1,x2` with rf x1=5, x2=7 -> next cycle: sel=0000, op_a=5, op_b=7, dest=3, wb=1, ready stays 1.
- `srai x4,x1,3` with x1=0xF0000000 -> sel=1101, op_b=3. Funct7 0100001 variant -> illegal_instr_o pulse, wb=0.
- `lui x5,0x12345` -> sel=0000, op_a=0, op_b=0x12345000. `addi x0,x1,1` -> wb=0.
- `addi x1,x0,9` then `add x2,x1,x1` back-to-back:
  - With FORWARDING_EN: ready=0 for 1 cycle, one bubble, then op_a=op_b=9 taken from alu_res_i.
  - Without FORWARDING_EN: 2 bubbles, operands taken from rf.
- rst_i asserted during a stall -> all outputs 0, state RUN, ready=1 the cycle after release.
- instr_valid_i toggled randomly, 50 independent ops -> issued sequence equals the accepted sequence with no loss or duplication.

Source files
------------

// File: rtl/jedro_1_defines.sv
// Shared constants for the jedro_1 decode/ALU boundary: widths, ALU select
// encodings, RV32I opcodes and the decoder stall FSM state type.
package jedro_1_defines;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 4;

  // ALU select is {funct7[5], funct3}
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } dec_state_e;

endpackage

// File: rtl/jedro_1_instr_fields.sv
// Combinational field extraction, immediate generation and legality check
// for the OP, OP-IMM and LUI instruction classes.
module jedro_1_instr_fields
  import jedro_1_defines::*;
(
  input  logic [31:0]               instr_i,
  output logic [REG_ADDR_WIDTH-1:0] rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_sel_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic                      legal_o,
  output logic                      uses_rs1_o,
  output logic                      uses_rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd_o   = instr_i[11:7];
  assign rs1_o  = instr_i[19:15];
  assign rs2_o  = instr_i[24:20];

  always_comb begin
    alu_sel_o  = ALU_OP_ADD;
    imm_o      = '0;
    legal_o    = 1'b0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
        alu_sel_o  = {funct7[5], funct3};
        legal_o    = (funct7 == FUNCT7_ZERO) ||
                     ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPCODE_OP_IMM: begin
        uses_rs1_o = 1'b1;
        imm_o      = {{20{instr_i[31]}}, instr_i[31:20]};
        alu_sel_o  = {1'b0, funct3};
        legal_o    = 1'b1;
        // Shift immediates carry only the 5-bit shamt; funct7 is an opcode extension there.
        if (funct3 == 3'b001) begin
          imm_o   = {27'd0, instr_i[24:20]};
          legal_o = (funct7 == FUNCT7_ZERO);
        end else if (funct3 == 3'b101) begin
          imm_o     = {27'd0, instr_i[24:20]};
          alu_sel_o = {funct7[5], funct3};
          legal_o   = (funct7 == FUNCT7_ZERO) || (funct7 == FUNCT7_ALT);
        end
      end
      OPCODE_LUI: begin
        imm_o   = {instr_i[31:12], 12'd0};
        legal_o = 1'b1;
      end
      default: ;
    endcase
    // An illegal instruction reads nothing, so it can never stall.
    if (!legal_o) begin
      uses_rs1_o = 1'b0;
      uses_rs2_o = 1'b0;
    end
  end

endmodule

// File: rtl/jedro_1_alu_decoder.sv
// Decode/issue stage in front of the ALU with RAW stall FSM.
// Define JEDRO_1_FORWARDING_EN to add the alu_res_i forwarding path.
module jedro_1_alu_decoder
  import jedro_1_defines::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               instr_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_a_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_b_o,
  input  logic [DATA_WIDTH-1:0]     rf_data_a_i,
  input  logic [DATA_WIDTH-1:0]     rf_data_b_i,
  input  logic [DATA_WIDTH-1:0]     alu_res_i,
  input  logic [REG_ADDR_WIDTH-1:0] alu_dest_addr_i,
  input  logic                      alu_wb_i,
  output logic [ALU_OP_WIDTH-1:0]   alu_sel_o,
  output logic [DATA_WIDTH-1:0]     alu_op_a_o,
  output logic [DATA_WIDTH-1:0]     alu_op_b_o,
  output logic [REG_ADDR_WIDTH-1:0] alu_dest_addr_o,
  output logic                      alu_wb_o,
  output logic                      illegal_instr_o
);

  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [ALU_OP_WIDTH-1:0]   dec_sel;
  logic [DATA_WIDTH-1:0]     dec_imm;
  logic                      dec_legal, uses_rs1, uses_rs2;

  dec_state_e                state_q, state_d;
  logic [1:0]                stall_cnt_q, stall_cnt_d;
  logic [ALU_OP_WIDTH-1:0]   alu_sel_q, alu_sel_d;
  logic [DATA_WIDTH-1:0]     alu_op_a_q, alu_op_a_d;
  logic [DATA_WIDTH-1:0]     alu_op_b_q, alu_op_b_d;
  logic [REG_ADDR_WIDTH-1:0] alu_dest_addr_q, alu_dest_addr_d;
  logic                      alu_wb_q, alu_wb_d;
  logic                      illegal_q, illegal_d;

  jedro_1_instr_fields u_fields (
    .instr_i    (instr_i),
    .rs1_o      (rs1),
    .rs2_o      (rs2),
    .rd_o       (rd),
    .alu_sel_o  (dec_sel),
    .imm_o      (dec_imm),
    .legal_o    (dec_legal),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  assign rf_addr_a_o = rs1;
  assign rf_addr_b_o = rs2;

  logic rs1_live, rs2_live, hit_out;
  logic [1:0] stall_need;
  logic [DATA_WIDTH-1:0] src_a, src_b;

  // x0 sources are never live: they read zero and cannot create a hazard.
  assign rs1_live = uses_rs1 && (rs1 != '0);
  assign rs2_live = uses_rs2 && (rs2 != '0);
  assign hit_out  = alu_wb_q && ((rs1_live && (rs1 == alu_dest_addr_q)) ||
                                 (rs2_live && (rs2 == alu_dest_addr_q)));

`ifdef JEDRO_1_FORWARDING_EN
  logic fwd_a, fwd_b;
  assign fwd_a      = alu_wb_i && rs1_live && (rs1 == alu_dest_addr_i);
  assign fwd_b      = alu_wb_i && rs2_live && (rs2 == alu_dest_addr_i);
  assign stall_need = hit_out ? 2'd1 : 2'd0;
  assign src_a      = !rs1_live ? '0 : (fwd_a ? alu_res_i : rf_data_a_i);
  assign src_b      = !rs2_live ? '0 : (fwd_b ? alu_res_i : rf_data_b_i);
`else
  logic hit_res;
  logic unused_alu_res;
  assign hit_res    = alu_wb_i && ((rs1_live && (rs1 == alu_dest_addr_i)) ||
                                   (rs2_live && (rs2 == alu_dest_addr_i)));
  // Without forwarding, an ALU-stage result lands in the RF one edge later.
  assign stall_need = hit_out ? 2'd2 : (hit_res ? 2'd1 : 2'd0);
  assign src_a      = rs1_live ? rf_data_a_i : '0;
  assign src_b      = rs2_live ? rf_data_b_i : '0;
  assign unused_alu_res = ^alu_res_i;
`endif

  logic hazard, xfer;
  assign hazard = instr_valid_i && (stall_need != 2'd0);

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    instr_ready_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          // The detection cycle itself is the first bubble.
          if (stall_need > 2'd1) begin
            state_d     = ST_STALL;
            stall_cnt_d = stall_need - 2'd1;
          end
        end else begin
          instr_ready_o = 1'b1;
        end
      end
      ST_STALL: begin
        stall_cnt_d = stall_cnt_q - 2'd1;
        if (stall_cnt_q <= 2'd1) begin
          state_d     = ST_RUN;
          stall_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d     = ST_RUN;
        stall_cnt_d = 2'd0;
      end
    endcase
  end

  assign xfer = instr_valid_i && instr_ready_o;

  always_comb begin
    alu_sel_d       = ALU_OP_ADD;
    alu_op_a_d      = '0;
    alu_op_b_d      = '0;
    alu_dest_addr_d = '0;
    alu_wb_d        = 1'b0;
    illegal_d       = 1'b0;
    if (xfer) begin
      if (dec_legal) begin
        alu_sel_d       = dec_sel;
        alu_op_a_d      = src_a;
        alu_op_b_d      = uses_rs2 ? src_b : dec_imm;
        alu_dest_addr_d = rd;
        alu_wb_d        = (rd != '0);
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_RUN;
      stall_cnt_q     <= 2'd0;
      alu_sel_q       <= ALU_OP_ADD;
      alu_op_a_q      <= '0;
      alu_op_b_q      <= '0;
      alu_dest_addr_q <= '0;
      alu_wb_q        <= 1'b0;
      illegal_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      alu_sel_q       <= alu_sel_d;
      alu_op_a_q      <= alu_op_a_d;
      alu_op_b_q      <= alu_op_b_d;
      alu_dest_addr_q <= alu_dest_addr_d;
      alu_wb_q        <= alu_wb_d;
      illegal_q       <= illegal_d;
    end
  end

  assign alu_sel_o       = alu_sel_q;
  assign alu_op_a_o      = alu_op_a_q;
  assign alu_op_b_o      = alu_op_b_q;
  assign alu_dest_addr_o = alu_dest_addr_q;
  assign alu_wb_o        = alu_wb_q;
  assign illegal_instr_o = illegal_q;

endmodule

// File: tb/tb_jedro_1_alu_decoder.sv
// Scoreboard bench for jedro_1_alu_decoder with a behavioural ALU stage and
// register file around it; honours JEDRO_1_FORWARDING_EN for stall counts.
module tb_jedro_1_alu_decoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [4:0]  rf_addr_a_o, rf_addr_b_o;
  logic [31:0] rf_data_a_i, rf_data_b_i;
  logic [31:0] alu_res_r;
  logic [4:0]  alu_dest_r;
  logic        alu_wb_r;
  logic [3:0]  alu_sel_o;
  logic [31:0] alu_op_a_o, alu_op_b_o;
  logic [4:0]  alu_dest_addr_o;
  logic        alu_wb_o, illegal_instr_o;

  logic [31:0] rf   [32];
  logic [31:0] arch [32];
  logic        rf_init = 1'b1;
  logic [74:0] sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

`ifdef JEDRO_1_FORWARDING_EN
  localparam int EXP_RAW_STALL = 1;
`else
  localparam int EXP_RAW_STALL = 2;
`endif

  always #5 clk = ~clk;

  jedro_1_alu_decoder dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .instr_i         (instr_i),
    .instr_valid_i   (instr_valid_i),
    .instr_ready_o   (instr_ready_o),
    .rf_addr_a_o     (rf_addr_a_o),
    .rf_addr_b_o     (rf_addr_b_o),
    .rf_data_a_i     (rf_data_a_i),
    .rf_data_b_i     (rf_data_b_i),
    .alu_res_i       (alu_res_r),
    .alu_dest_addr_i (alu_dest_r),
    .alu_wb_i        (alu_wb_r),
    .alu_sel_o       (alu_sel_o),
    .alu_op_a_o      (alu_op_a_o),
    .alu_op_b_o      (alu_op_b_o),
    .alu_dest_addr_o (alu_dest_addr_o),
    .alu_wb_o        (alu_wb_o),
    .illegal_instr_o (illegal_instr_o)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'd0;
    if (i == 1) return 32'd5;
    if (i == 2) return 32'd7;
    return 32'h1111_1111 * i;
  endfunction

  function automatic logic [31:0] alu_fn(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU result register and register file (write one edge after the ALU register).
  assign rf_data_a_i = rf[rf_addr_a_o];
  assign rf_data_b_i = rf[rf_addr_b_o];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (alu_wb_r && (alu_dest_r != 5'd0)) begin
      rf[alu_dest_r] <= alu_res_r;
    end
    if (rst_i) begin
      alu_res_r  <= '0;
      alu_dest_r <= '0;
      alu_wb_r   <= 1'b0;
    end else begin
      alu_res_r  <= alu_fn(alu_sel_o, alu_op_a_o, alu_op_b_o);
      alu_dest_r <= alu_dest_addr_o;
      alu_wb_r   <= alu_wb_o;
    end
  end

  task automatic check_eq(input string tag, input logic [74:0] got, input logic [74:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ISA-level expectation {sel, op_a, op_b, dest, wb, illegal} from architectural state.
  function automatic logic [74:0] model(input logic [31:0] ins);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        legal;
    logic [3:0]  sel;
    logic [31:0] a, b;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
    legal = 1'b0; sel = 4'd0; a = 32'd0; b = 32'd0;
    case (opc)
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        sel = {f7[5], f3}; a = arch[rs1]; b = arch[rs2];
      end
      7'h13: begin
        a = arch[rs1];
        if (f3 == 3'd1) begin
          legal = (f7 == 7'h00); sel = 4'b0001; b = {27'd0, ins[24:20]};
        end else if (f3 == 3'd5) begin
          legal = (f7 == 7'h00) || (f7 == 7'h20); sel = {f7[5], 3'd5}; b = {27'd0, ins[24:20]};
        end else begin
          legal = 1'b1; sel = {1'b0, f3}; b = {{20{ins[31]}}, ins[31:20]};
        end
      end
      7'h37: begin
        legal = 1'b1; sel = 4'd0; a = 32'd0; b = {ins[31:12], 12'd0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) return {4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
    return {sel, a, b, rd, (rd != 5'd0), 1'b0};
  endfunction

  // Monitor: push on each accepted instruction, pop and compare after the issue edge.
  initial begin
    logic [74:0] e, got;
    bit          xfer;
    forever begin
      @(posedge clk);
      xfer = instr_valid_i && instr_ready_o && !rst_i;
      if (rf_init) for (int i = 0; i < 32; i++) arch[i] = init_val(i);
      if (xfer) begin
        e = model(instr_i);
        sb_q.push_back(e);
        if (e[1]) arch[e[6:2]] = alu_fn(e[74:71], e[70:39], e[38:7]);
        $display("issue instr=%08h sel=%h a=%08h b=%08h rd=%0d wb=%b ill=%b",
                 instr_i, e[74:71], e[70:39], e[38:7], e[6:2], e[1], e[0]);
      end
      #1;
      got = {alu_sel_o, alu_op_a_o, alu_op_b_o, alu_dest_addr_o, alu_wb_o, illegal_instr_o};
      if (xfer) e = sb_q.pop_front();
      else e = '0;
      check_eq(xfer ? "issue" : "bubble", got, e);
    end
  end

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] rand_instr();
    int          c;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    c   = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    if (c < 4)
      return r_type(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
    if (c < 8) begin
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return i_type(imm, rs1, f3, rd);
    end
    if (c == 8) return u_type(20'($urandom), rd);
    return {7'h00, rs2, rs1, f3, rd, 7'b1100011};
  endfunction

  // Present one instruction from a negedge and hold it until accepted.
  task automatic send(input logic [31:0] ins, output int stalls);
    bit acc;
    stalls = 0;
    acc = 1'b0;
    instr_i = ins;
    instr_valid_i = 1'b1;
    for (int cyc = 0; cyc < 16 && !acc; cyc++) begin
      #1;
      if (instr_ready_o) acc = 1'b1;
      else stalls++;
      @(negedge clk);
    end
    check_eq("accept", 75'(acc), 75'd1);
  endtask

  task automatic idle(input int n);
    instr_valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    rf_init = 1'b0;
    rst_i = 1'b0;
    check_eq("reset_outputs", {alu_sel_o, alu_op_a_o, alu_op_b_o, alu_dest_addr_o, alu_wb_o, illegal_instr_o}, 75'd0);
    #1;
    check_eq("ready_after_reset", 75'(instr_ready_o), 75'd1);
    @(negedge clk);

    send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), s);      // add x3,x1,x2
    check_eq("add_no_stall", 75'(s), 75'd0);
    send(u_type(20'hF0000, 5'd1), s);                   // lui x1,0xF0000
    send(i_type({7'h20, 5'd3}, 5'd1, 3'd5, 5'd4), s);   // srai x4,x1,3
    send(i_type({7'h21, 5'd3}, 5'd1, 3'd5, 5'd4), s);   // illegal funct7
    send(u_type(20'h12345, 5'd5), s);                   // lui x5,0x12345
    send(i_type(12'd1, 5'd1, 3'd0, 5'd0), s);           // addi x0,x1,1
    send(i_type(12'h400, 5'd2, 3'd0, 5'd3), s);         // addi with imm bit 10 set
    idle(3);

    send(i_type(12'd9, 5'd0, 3'd0, 5'd1), s);           // addi x1,x0,9
    send(r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), s);     // add x2,x1,x1
    check_eq("raw_stall_cycles", 75'(s), 75'(EXP_RAW_STALL));
    idle(3);

    // Reset in the middle of a stall
    send(i_type(12'd1, 5'd0, 3'd0, 5'd6), s);           // addi x6,x0,1
    instr_i = r_type(7'h00, 5'd6, 5'd6, 3'd0, 5'd7);    // add x7,x6,x6
    #1;
    check_eq("stall_ready_low", 75'(instr_ready_o), 75'd0);
    @(negedge clk);
    rst_i = 1'b1;
    instr_valid_i = 1'b0;
    @(negedge clk);
    check_eq("mid_stall_reset_outputs",
             {alu_sel_o, alu_op_a_o, alu_op_b_o, alu_dest_addr_o, alu_wb_o, illegal_instr_o}, 75'd0);
    rst_i = 1'b0;
    send(r_type(7'h00, 5'd6, 5'd6, 3'd0, 5'd7), s);
    check_eq("ready_after_stall_reset", 75'(s), 75'd0);

    for (int k = 0; k < 50; k++) begin
      idle($urandom_range(0, 2));
      send(rand_instr(), s);
    end
    idle(5);

    check_eq("scoreboard_empty", 75'(sb_q.size()), 75'd0);
    for (int i = 1; i < 8; i++) check_eq($sformatf("rf_x%0d", i), 75'(rf[i]), 75'(arch[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
